alu_uart_interface: RTL and testbench
=====================================

Name: alu_uart_interface

Overview:
- Host-side link between the byte-stream receiver/transmitter and the combinational alu.
- Collects a three-byte frame (operand A, operand B, op code), drives the latched values onto the ALU inputs, captures result/overflow/zero, and returns a two-byte reply (result, flags) through the transmitter handshake.
- Enables hardware operation of the ALU from a serial host instead of a simulation bench.

Parameters:
- NB_DATA, 8, operand/result width; also the byte width of the rx/tx stream.
- NB_OP, 6, ALU op code width; taken from the low NB_OP bits of the op byte.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes of one frame before the partial frame is discarded.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse: new byte on i_rx_data.
- o_data_a  out  NB_DATA  latched operand A to ALU i_data_a.
- o_data_b  out  NB_DATA  latched operand B to ALU i_data_b.
- o_operation_code  out  NB_OP  latched op code to ALU i_operation_code.
- i_alu_result  in  NB_DATA  ALU o_result.
- i_alu_overflow  in  1  ALU o_overflow.
- i_alu_zero  in  1  ALU o_zero.
- o_tx_data  out  NB_DATA  byte to transmitter, stable from o_tx_start until i_tx_done.
- o_tx_start  out  1  one-cycle pulse requesting transmission.
- i_tx_busy  in  1  transmitter busy; o_tx_start is never asserted while high.
- i_tx_done  in  1  one-cycle pulse: current byte fully sent.
- o_busy  out  1  high in every state except WAIT_A.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): state WAIT_A; all outputs 0; timeout counter 0; any frame or reply in progress is abandoned with no further o_tx_start.
- States and transitions:
  - WAIT_A: on rx_done, latch byte into o_data_a, go to WAIT_B.
  - WAIT_B: on rx_done, latch byte into o_data_b, go to WAIT_OP.
  - WAIT_OP: on rx_done, latch the low NB_OP bits into o_operation_code and record err.
    - err=1 if the upper 2 bits are non-zero or the op is not one of 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x03 SRA, 0x02 SRL, 0x27 NOR.
    - Go to COMPUTE.
  - COMPUTE: one cycle so ALU inputs settle. Capture res=i_alu_result and flags={5'b0,err,i_alu_overflow,i_alu_zero}. If err=1, res=0 and flags=0x04. Go to SEND_RES.
  - SEND_RES: when i_tx_busy=0, drive o_tx_data=res, pulse o_tx_start for one cycle, go to WAIT_RES.
  - WAIT_RES: on i_tx_done, go to SEND_FLAGS.
  - SEND_FLAGS / WAIT_FLAGS: same handshake with o_tx_data=flags; on i_tx_done go to WAIT_A.
- Latency: the first o_tx_start occurs no earlier than 2 cycles after the op-byte rx_done (COMPUTE, then SEND_RES with tx idle).
- Timeout: a counter runs only in WAIT_B and WAIT_OP. It clears on every rx_done and on state entry. When it reaches TIMEOUT_CYCLES-1, go to WAIT_A; o_data_a/o_data_b keep their stale values, no reply is sent. If rx_done and expiry occur in the same cycle, the byte wins.
- rx_done in COMPUTE through WAIT_FLAGS is dropped; the byte is not queued.
- o_data_a, o_data_b and o_operation_code hold their values until overwritten by the next frame.
- Arithmetic is done only by the ALU; this block performs no arithmetic.

Test Plan:
- Frame 0x7F,0x01,0x20 with a tx model (busy during send, done after 10 cycles) -> exactly two o_tx_start pulses; bytes 0x80 then 0x02; o_busy returns 0 after the second i_tx_done.
- Frame 0x05,0x05,0x22 -> reply 0x00,0x01; o_data_a=o_data_b=0x05 held afterwards.
- Frame 0x12,0x34,0x3F (invalid op) -> reply 0x00,0x04; op byte 0xE0 (upper bits set) -> reply 0x00,0x04.
- TIMEOUT_CYCLES=50: send 0x11,0x22, idle 60 cycles -> no tx, o_busy=0. Then frame 0x0C,0x0A,0x24 -> reply 0x08,0x00.
- Extra rx_done bytes during WAIT_RES -> ignored; next frame 0xF0,0x04,0x03 -> reply 0xFF,0x00 (SRA).
- Assert i_rst_n=0 for one cycle during WAIT_FLAGS -> no further o_tx_start; all outputs 0; next frame processes normally.

Source files
------------

// File: rtl/alu_uart_interface.sv
// -----------------------------------------------------------------------------
// alu_uart_interface
//   Bridges a byte-stream receiver/transmitter pair to a combinational ALU.
//   A host sends a three-byte frame: operand A, operand B and an op byte. The
//   block drives the latched operands and op code onto the ALU inputs, waits
//   one cycle for the ALU to settle, and captures the result and flags. It then
//   returns two bytes to the host, result first and flags second, using the
//   transmitter start/busy/done handshake.
//
//   Flags byte layout: {5'b0, err, overflow, zero}. When the op byte is
//   rejected, the reply is result=0 and flags=0x04.
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst_n          synchronous active-low reset
//   i_rx_data        received byte (valid with i_rx_done)
//   i_rx_done        one-cycle pulse, new byte available
//   o_data_a         latched operand A to the ALU
//   o_data_b         latched operand B to the ALU
//   o_operation_code latched op code to the ALU
//   i_alu_result     ALU result
//   i_alu_overflow   ALU overflow flag
//   i_alu_zero       ALU zero flag
//   o_tx_data        byte for the transmitter, held from start until done
//   o_tx_start       one-cycle transmit request, issued only when tx is idle
//   i_tx_busy        transmitter busy
//   i_tx_done        one-cycle pulse, byte fully sent
//   o_busy           high whenever a frame or reply is in progress
// -----------------------------------------------------------------------------
module alu_uart_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_operation_code,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_overflow,
  input  logic               i_alu_zero,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_busy,
  input  logic               i_tx_done,
  output logic               o_busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_WAIT_A     = 3'd0,
    ST_WAIT_B     = 3'd1,
    ST_WAIT_OP    = 3'd2,
    ST_COMPUTE    = 3'd3,
    ST_SEND_RES   = 3'd4,
    ST_WAIT_RES   = 3'd5,
    ST_SEND_FLAGS = 3'd6,
    ST_WAIT_FLAGS = 3'd7
  } state_t;

  // Rejects op bytes whose bits above the op-code field are set, and op codes
  // outside the supported ALU set.
  function automatic logic op_invalid(input logic [NB_DATA-1:0] op_byte);
    logic bad;
    bad = 1'b0;
    if (op_byte[NB_DATA-1:NB_OP] != '0) begin
      bad = 1'b1;
    end else begin
      case (op_byte[NB_OP-1:0])
        NB_OP'(6'h20), NB_OP'(6'h22), NB_OP'(6'h24), NB_OP'(6'h25),
        NB_OP'(6'h26), NB_OP'(6'h03), NB_OP'(6'h02), NB_OP'(6'h27): bad = 1'b0;
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  state_t               state_r, state_nx;
  logic [CNT_W-1:0]     cnt_r, cnt_nx;
  logic [NB_DATA-1:0]   data_a_r, data_b_r, res_r, flags_r, tx_data_r;
  logic [NB_OP-1:0]     op_r;
  logic                 err_r, tx_start_r, busy_r;
  logic                 load_a_s, load_b_s, load_op_s, capture_s;
  logic                 send_res_s, send_flags_s;

  // Next-state, idle-timeout counter and datapath load strobes.
  always_comb begin
    state_nx     = state_r;
    cnt_nx       = '0;
    load_a_s     = 1'b0;
    load_b_s     = 1'b0;
    load_op_s    = 1'b0;
    capture_s    = 1'b0;
    send_res_s   = 1'b0;
    send_flags_s = 1'b0;
    case (state_r)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          load_a_s = 1'b1;
          state_nx = ST_WAIT_B;
        end else begin
          state_nx = ST_WAIT_A;
        end
      end
      // A received byte takes priority over an expiring timeout.
      ST_WAIT_B: begin
        if (i_rx_done) begin
          load_b_s = 1'b1;
          state_nx = ST_WAIT_OP;
        end else if (cnt_r == CNT_LAST) begin
          state_nx = ST_WAIT_A;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1'b1);
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          load_op_s = 1'b1;
          state_nx  = ST_COMPUTE;
        end else if (cnt_r == CNT_LAST) begin
          state_nx = ST_WAIT_A;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1'b1);
        end
      end
      // ALU inputs were latched on entry; result is valid by now.
      ST_COMPUTE: begin
        capture_s = 1'b1;
        state_nx  = ST_SEND_RES;
      end
      ST_SEND_RES: begin
        if (!i_tx_busy) begin
          send_res_s = 1'b1;
          state_nx   = ST_WAIT_RES;
        end else begin
          state_nx = ST_SEND_RES;
        end
      end
      ST_WAIT_RES: begin
        if (i_tx_done) begin
          state_nx = ST_SEND_FLAGS;
        end else begin
          state_nx = ST_WAIT_RES;
        end
      end
      ST_SEND_FLAGS: begin
        if (!i_tx_busy) begin
          send_flags_s = 1'b1;
          state_nx     = ST_WAIT_FLAGS;
        end else begin
          state_nx = ST_SEND_FLAGS;
        end
      end
      ST_WAIT_FLAGS: begin
        if (i_tx_done) begin
          state_nx = ST_WAIT_A;
        end else begin
          state_nx = ST_WAIT_FLAGS;
        end
      end
      default: begin
        state_nx = ST_WAIT_A;
      end
    endcase
  end

  // State and timeout counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_WAIT_A;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
    end
  end

  // Operand/op latches, result capture and transmit request registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      data_a_r   <= '0;
      data_b_r   <= '0;
      op_r       <= '0;
      err_r      <= 1'b0;
      res_r      <= '0;
      flags_r    <= '0;
      tx_data_r  <= '0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      if (load_a_s) begin
        data_a_r <= i_rx_data;
      end
      if (load_b_s) begin
        data_b_r <= i_rx_data;
      end
      if (load_op_s) begin
        op_r  <= i_rx_data[NB_OP-1:0];
        err_r <= op_invalid(i_rx_data);
      end
      // A rejected op masks whatever the ALU produced.
      if (capture_s) begin
        if (err_r) begin
          res_r   <= '0;
          flags_r <= NB_DATA'(8'h04);
        end else begin
          res_r   <= i_alu_result;
          flags_r <= {{(NB_DATA-3){1'b0}}, 1'b0, i_alu_overflow, i_alu_zero};
        end
      end
      // tx_data only moves when a new byte is launched, so it stays stable
      // for the whole transmission.
      if (send_res_s) begin
        tx_data_r <= res_r;
      end else if (send_flags_s) begin
        tx_data_r <= flags_r;
      end
      tx_start_r <= send_res_s | send_flags_s;
      busy_r     <= (state_nx != ST_WAIT_A);
    end
  end

  assign o_data_a         = data_a_r;
  assign o_data_b         = data_b_r;
  assign o_operation_code = op_r;
  assign o_tx_data        = tx_data_r;
  assign o_tx_start       = tx_start_r;
  assign o_busy           = busy_r;

endmodule

// File: tb/tb_alu_uart_interface.sv
// -----------------------------------------------------------------------------
// tb_alu_uart_interface
//   Bench for alu_uart_interface. A behavioural ALU and a transmitter model
//   surround the design. Each frame pushes its expected reply bytes into a
//   queue; an independent monitor pops and compares on every o_tx_start.
// -----------------------------------------------------------------------------
module tb_alu_uart_interface;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] data_a, data_b, tx_data, alu_res;
  logic [5:0] op_code;
  logic       tx_start, busy, alu_ovf, alu_zero;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;

  int checks = 0;
  int errors = 0;
  int tx_count = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  alu_uart_interface #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(50)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_data_a(data_a), .o_data_b(data_b), .o_operation_code(op_code),
    .i_alu_result(alu_res), .i_alu_overflow(alu_ovf), .i_alu_zero(alu_zero),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_busy(tx_busy),
    .i_tx_done(tx_done), .o_busy(busy)
  );

  // Behavioural ALU: returns {overflow, zero, result}. Unknown ops give junk
  // with both flags set so that the design's masking is visible.
  function automatic logic [9:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
    int sa, sb, s;
    logic [7:0] r;
    logic v, z;
    sa = $signed(a);
    sb = $signed(b);
    v = 1'b0;
    case (op)
      6'h20: begin s = sa + sb; r = 8'(s); v = (s > 127) || (s < -128); end
      6'h22: begin s = sa - sb; r = 8'(s); v = (s > 127) || (s < -128); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h03: r = 8'(sa >>> b);
      6'h02: r = a >> b;
      default: begin r = a ^ b ^ 8'h5A; v = 1'b1; end
    endcase
    z = (r == 8'h00);
    if (op != 6'h20 && op != 6'h22 && op != 6'h24 && op != 6'h25 &&
        op != 6'h26 && op != 6'h27 && op != 6'h03 && op != 6'h02) z = 1'b1;
    return {v, z, r};
  endfunction

  assign {alu_ovf, alu_zero, alu_res} = alu_eval(data_a, data_b, op_code);

  // Reference reply for a host frame.
  task automatic ref_reply(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           output logic [7:0] res, output logic [7:0] flags);
    logic [9:0] e;
    logic ok;
    ok = (opb[7:6] == 2'b00) && (opb[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25,
                                                   6'h26, 6'h03, 6'h02, 6'h27});
    if (!ok) begin
      res = 8'h00;
      flags = 8'h04;
    end else begin
      e = alu_eval(a, b, opb[5:0]);
      res = e[7:0];
      flags = {6'b000000, e[9], e[8]};
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Transmitter model: busy for 10 cycles after a start, then a done pulse.
  initial begin
    logic [7:0] held;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        check8("start_while_busy", {7'b0, tx_busy}, 8'h00);
        tx_busy = 1'b1;
        held = tx_data;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (busy) check8("tx_data_stable", tx_data, held);
        end
        tx_done = 1'b1;
        tx_busy = 1'b0;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every transmitted byte must match the queue head.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got 0x%02h expected no transmission", tx_data);
        end else begin
          e = exp_q.pop_front();
          check8("tx_byte", tx_data, e);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
    logic [7:0] r, f;
    ref_reply(a, b, opb, r, f);
    exp_q.push_back(r);
    exp_q.push_back(f);
    send_byte(a);
    send_byte(b);
    send_byte(opb);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy || tx_busy || tx_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check8("reply_complete", {7'b0, n >= budget}, 8'h00);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int n = 0;
    while (tx_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check8("tx_reached", {7'b0, n >= budget}, 8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    check8({tag, "_data_a"}, data_a, 8'h00);
    check8({tag, "_data_b"}, data_b, 8'h00);
    check8({tag, "_op"}, {2'b00, op_code}, 8'h00);
    check8({tag, "_tx_data"}, tx_data, 8'h00);
    check8({tag, "_tx_start"}, {7'b0, tx_start}, 8'h00);
    check8({tag, "_busy"}, {7'b0, busy}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] ops [8];
    logic [7:0] opb;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Signed overflow on ADD, exactly two reply bytes.
    base = tx_count;
    send_frame(8'h7F, 8'h01, 8'h20);
    wait_idle(200);
    check8("two_starts", 8'(tx_count - base), 8'h02);
    check8("busy_after_reply", {7'b0, busy}, 8'h00);

    // Zero result; operands held afterwards.
    send_frame(8'h05, 8'h05, 8'h22);
    wait_idle(200);
    check8("held_a", data_a, 8'h05);
    check8("held_b", data_b, 8'h05);

    // Unsupported op code, then upper bits set.
    send_frame(8'h12, 8'h34, 8'h3F);
    wait_idle(200);
    check8("held_op", {2'b00, op_code}, 8'h3F);
    send_frame(8'h01, 8'h02, 8'hE0);
    wait_idle(200);
    check8("op_low_bits", {2'b00, op_code}, 8'h20);

    // Partial frame abandoned by the idle timeout.
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (60) @(negedge clk);
    check8("timeout_busy", {7'b0, busy}, 8'h00);
    check8("timeout_stale_a", data_a, 8'h11);
    check8("timeout_stale_b", data_b, 8'h22);
    send_frame(8'h0C, 8'h0A, 8'h24);
    wait_idle(200);

    // Bytes arriving while a reply is in flight are dropped.
    base = tx_count;
    send_frame(8'h10, 8'h20, 8'h25);
    wait_tx(base + 1, 200);
    send_byte(8'h99);
    send_byte(8'h77);
    wait_idle(200);
    send_frame(8'hF0, 8'h04, 8'h03);
    wait_idle(200);

    // Reset while the flags byte is being sent.
    base = tx_count;
    send_frame(8'h03, 8'h04, 8'h27);
    wait_tx(base + 2, 200);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("midreset");
    wait_idle(200);
    send_frame(8'h80, 8'h80, 8'h20);
    wait_idle(200);

    // Randomised frames, mostly valid ops with occasional arbitrary op bytes.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 9) < 8) opb = ops[$urandom_range(0, 7)];
      else opb = 8'($urandom);
      send_frame(8'($urandom), 8'($urandom), opb);
      wait_idle(200);
    end

    check8("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
